// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and the bit-vote helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_WAIT_HIGH = 3'd0,
    RX_IDLE      = 3'd1,
    RX_START     = 3'd2,
    RX_DATA      = 3'd3,
    RX_STOP      = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: head entry is presented combinationally; push and pop are registered.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned W       = UART_DATA_BITS
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  logic [W-1:0]       mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with input synchroniser, 3-sample majority vote per bit,
// framing/break detection and a valid/ready show-ahead receive FIFO.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 50,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  input  logic       i_RX_Ready,
  output logic       o_Frame_Err,
  output logic       o_Break,
  output logic       o_Overrun,
  output logic       o_RX_Busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] SAMP0 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] SAMP1 = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] VOTE  = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  rx_state_e                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [1:0]                samp_q, samp_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      fe_q, fe_d;
  logic                      brk_q, brk_d;
  logic                      ovr_q, ovr_d;

  logic s, at_vote, wrap, vote, push, pop, fifo_full, fifo_empty;

  assign s       = sync_q[1];
  assign at_vote = (cnt_q == VOTE);
  assign wrap    = (cnt_q == LAST);
  assign vote    = maj3(samp_q[0], samp_q[1], s);
  assign pop     = o_RX_DV & i_RX_Ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    samp_d  = samp_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_d    = 1'b0;
    brk_d   = 1'b0;
    if (cnt_q == SAMP0) samp_d[0] = s;
    if (cnt_q == SAMP1) samp_d[1] = s;
    case (state_q)
      RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (s) state_d = RX_IDLE;
      end
      RX_IDLE: begin
        cnt_d = '0;
        if (!s) state_d = RX_START;
      end
      RX_START: begin
        if (at_vote && vote) begin
          state_d = RX_IDLE;
        end else if (wrap) begin
          state_d = RX_DATA;
          idx_d   = '0;
        end
      end
      RX_DATA: begin
        if (at_vote) shift_d[idx_q] = vote;
        if (wrap) begin
          if (idx_q == LAST_IDX) state_d = RX_STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        // Leave half a bit early on a good stop so the next start edge is not missed.
        if (at_vote) begin
          if (vote) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            if (shift_q == '0) brk_d = 1'b1;
            else               fe_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end
      end
      default: state_d = RX_WAIT_HIGH;
    endcase
    ovr_d = push & fifo_full & ~pop;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q  <= '1;
      state_q <= RX_WAIT_HIGH;
      cnt_q   <= '0;
      samp_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_RX_Serial};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end

  uart_rx_fifo #(
    .FIFO_AW (FIFO_AW),
    .W       (UART_DATA_BITS)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_ni  (i_Rst_L),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (o_RX_Byte)
  );

  assign o_RX_DV     = ~fifo_empty;
  assign o_Frame_Err = fe_q;
  assign o_Break     = brk_q;
  assign o_Overrun   = ovr_q;
  assign o_RX_Busy   = (state_q != RX_IDLE);

endmodule
